acc_access_arbiter: RTL and testbench
=====================================

ACC_ACCESS_ARBITER -- requirements
Module: acc_access_arbiter

Interface
REQ-001 Parameter addr_width, default 64, acc address width (AW).
REQ-002 Parameter data_width, default 32, acc data width (DW).
REQ-003 Parameter timeout_cycles, default 255, 16-bit, max target wait cycles; 0 disables the watchdog.
REQ-004 sys__clk  in  1  single clock; all logic on rising edge.
REQ-005 sys__arstn  in  1  asynchronous active-low reset.
REQ-006 m__waddr  in  2*AW  requester write address; slice i = requester i (i = 0,1).
REQ-007 m__wdata  in  2*DW  requester write data.
REQ-008 m__wvalid  in  2  requester write request.
REQ-009 m__wready  out  2  requester write completion.
REQ-010 m__raddr  in  2*AW  requester read address.
REQ-011 m__rdata  out  2*DW  requester read data.
REQ-012 m__rvalid  in  2  requester read request.
REQ-013 m__rready  out  2  requester read completion.
REQ-014 s__waddr / s__wdata  out  AW / DW  target write address/data.
REQ-015 s__wvalid  out  1  target write request; s__wready  in  1  target write accept.
REQ-016 s__raddr  out  AW  target read address; s__rdata  in  DW  target read data.
REQ-017 s__rvalid  out  1  target read request; s__rready  in  1  target read accept.
REQ-018 arb__timeout  out  1  one-cycle registered pulse per watchdog expiry.
REQ-019 arb__timeout_cnt  out  8  saturating count of expiries.

Function
REQ-020 Requester protocol: valid and address/data SHALL be held stable until the matching ready; ready is a one-cycle pulse; rdata is valid only in the ready cycle.
REQ-021 Four request slots SHALL be arbitrated: 0=m0 write, 1=m0 read, 2=m1 write, 3=m1 read; only one transaction is outstanding on the target at any time.
REQ-022 FSM SHALL have states IDLE and XFER; IDLE->XFER when any slot requests, XFER->IDLE on target ready or watchdog expiry.
REQ-023 In IDLE the winning slot SHALL be registered as a one-hot grant using round-robin starting at pointer p; after reset p=0.
REQ-024 On completion of slot k, p SHALL become (k+1) mod 4.
REQ-025 In XFER, s__wvalid (write slot) or s__rvalid (read slot) SHALL be 1, and s__waddr/s__wdata/s__raddr SHALL mux combinationally from the granted requester; the non-granted channel valid is 0.
REQ-026 Latency: request first visible in cycle N -> target valid in N+1; target ready in cycle M -> requester ready in M (combinational), IDLE in M+1, next target valid earliest at M+2.
REQ-027 m__rdata granted slice SHALL equal s__rdata in the completion cycle; all other slices/cycles are 0.
REQ-028 Watchdog counter SHALL clear on IDLE->XFER and increment each XFER cycle without target ready; when the XFER has lasted timeout_cycles cycles without ready, the requester SHALL receive ready in that cycle (read data 32'hDEADBEEF, low DW bits), and FSM returns to IDLE.
REQ-029 Target ready in the expiry cycle SHALL take precedence: normal completion, no timeout pulse.
REQ-030 arb__timeout SHALL pulse the cycle after expiry; arb__timeout_cnt increments and saturates at 255.
REQ-031 A requester deasserting valid during its own XFER is illegal; behaviour unspecified.
REQ-032 Target ready asserted in IDLE SHALL be ignored.

Reset
REQ-033 On sys__arstn low, immediately: FSM=IDLE, grant=0, p=0, watchdog=0, arb__timeout=0, arb__timeout_cnt=0; all ready/valid outputs 0, m__rdata 0; s__ address/data outputs 0.
REQ-034 Reset during XFER SHALL abort the transaction without any requester ready; first grant after release is per p=0.

Verification
REQ-035 Single write: m0 write addr 0x10 data 0xA5A5A5A5, target ready 2 cycles after s__wvalid -> s__waddr=0x10, s__wdata=0xA5A5A5A5, m__wready[0] one cycle, coincident with s__wready.
REQ-036 All four slots requesting from reset -> grant order 0,1,2,3,0 with target valids 2 cycles apart when target ready is immediate.
REQ-037 m1 read, s__rdata=0x12345678 with s__rready -> m__rdata[63:32]=0x12345678 and m__rready[1] in same cycle, m__rdata[31:0]=0.
REQ-038 timeout_cycles=4, target never ready, m0 read -> m__rready[0] after 4 XFER cycles with data 0xDEADBEEF, arb__timeout pulse next cycle, cnt=1; repeated 300 times -> cnt=255.
REQ-039 Ready on expiry cycle -> normal data, no pulse; async reset mid-XFER -> all outputs 0 instantly, no ready issued.

Source files
------------

// File: rtl/acc_access_arbiter.sv
// acc_access_arbiter: round-robin arbiter of two requesters (write+read each)
// onto one single-outstanding target port, with a transaction watchdog.
module acc_access_arbiter #(
    parameter int          addr_width     = 64,
    parameter int          data_width     = 32,
    parameter logic [15:0] timeout_cycles = 16'd255
) (
    input  logic                      sys__clk,
    input  logic                      sys__arstn,
    input  logic [2*addr_width-1:0]   m__waddr,
    input  logic [2*data_width-1:0]   m__wdata,
    input  logic [1:0]                m__wvalid,
    output logic [1:0]                m__wready,
    input  logic [2*addr_width-1:0]   m__raddr,
    output logic [2*data_width-1:0]   m__rdata,
    input  logic [1:0]                m__rvalid,
    output logic [1:0]                m__rready,
    output logic [addr_width-1:0]     s__waddr,
    output logic [data_width-1:0]     s__wdata,
    output logic                      s__wvalid,
    input  logic                      s__wready,
    output logic [addr_width-1:0]     s__raddr,
    input  logic [data_width-1:0]     s__rdata,
    output logic                      s__rvalid,
    input  logic                      s__rready,
    output logic                      arb__timeout,
    output logic [7:0]                arb__timeout_cnt
);

    localparam int AW = addr_width;
    localparam int DW = data_width;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam logic [DW-1:0] DEAD_DATA = DW'(32'hDEADBEEF);

    logic [0:0]  state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] wdog_q, wdog_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  tcnt_q, tcnt_d;

    logic [3:0]  req;
    logic [3:0]  pick;
    logic [1:0]  rr_idx;
    logic        found;
    logic        xfer;
    logic        is_wr;
    logic        sel_m1;
    logic        tgt_rdy;
    logic        expire;
    logic        done;
    logic [1:0]  gnt_idx;
    logic [DW-1:0] rd_val;

    // slot order: 0=m0 write, 1=m0 read, 2=m1 write, 3=m1 read
    assign req = {m__rvalid[1], m__wvalid[1], m__rvalid[0], m__wvalid[0]};

    assign xfer    = (state_q == ST_XFER);
    assign is_wr   = gnt_q[0] | gnt_q[2];
    assign sel_m1  = gnt_q[2] | gnt_q[3];
    assign gnt_idx = {gnt_q[2] | gnt_q[3], gnt_q[1] | gnt_q[3]};
    assign tgt_rdy = xfer & (is_wr ? s__wready : s__rready);
    assign expire  = xfer & (timeout_cycles != 16'd0)
                   & (wdog_q == timeout_cycles - 16'd1);
    assign done    = tgt_rdy | expire;
    assign rd_val  = tgt_rdy ? s__rdata : DEAD_DATA;

    // round-robin pick: first requesting slot at or after the pointer
    always_comb begin
        pick   = 4'b0000;
        found  = 1'b0;
        rr_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rr_idx = ptr_q + 2'(i);
            if (!found && req[rr_idx]) begin
                pick  = 4'b0001 << rr_idx;
                found = 1'b1;
            end
        end
    end

    // FSM, grant, pointer, watchdog and expiry counter next-state
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        tmo_d   = 1'b0;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_XFER;
                    gnt_d   = pick;
                    wdog_d  = 16'd0;
                end
            end
            default: begin
                if (done) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    ptr_d   = gnt_idx + 2'd1;
                    if (!tgt_rdy) begin
                        tmo_d = 1'b1;
                        if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
        endcase
    end

    // state registers, cleared immediately by reset
    always_ff @(posedge sys__clk or negedge sys__arstn) begin
        if (!sys__arstn) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            ptr_q   <= 2'd0;
            wdog_q  <= 16'd0;
            tmo_q   <= 1'b0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // target side: valid and muxed address/data only while transferring
    always_comb begin
        s__wvalid = xfer & is_wr;
        s__rvalid = xfer & ~is_wr;
        s__waddr  = '0;
        s__wdata  = '0;
        s__raddr  = '0;
        if (xfer) begin
            s__waddr = sel_m1 ? m__waddr[2*AW-1:AW] : m__waddr[AW-1:0];
            s__wdata = sel_m1 ? m__wdata[2*DW-1:DW] : m__wdata[DW-1:0];
            s__raddr = sel_m1 ? m__raddr[2*AW-1:AW] : m__raddr[AW-1:0];
        end
    end

    // requester side: completion pulses and read data in the done cycle
    always_comb begin
        m__wready = {done & is_wr & sel_m1, done & is_wr & ~sel_m1};
        m__rready = {done & ~is_wr & sel_m1, done & ~is_wr & ~sel_m1};
        m__rdata  = '0;
        if (m__rready[1]) m__rdata[2*DW-1:DW] = rd_val;
        if (m__rready[0]) m__rdata[DW-1:0]    = rd_val;
    end

    assign arb__timeout     = tmo_q;
    assign arb__timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_acc_access_arbiter.sv
// tb_acc_access_arbiter: vector table plus directed sequences for
// arbitration order, watchdog expiry/saturation and async reset.
module tb_acc_access_arbiter;

    logic         clk;
    logic         rst_n;
    logic [127:0] m_waddr;
    logic [63:0]  m_wdata;
    logic [1:0]   m_wvalid;
    logic [1:0]   m_wready;
    logic [127:0] m_raddr;
    logic [63:0]  m_rdata;
    logic [1:0]   m_rvalid;
    logic [1:0]   m_rready;
    logic [63:0]  s_waddr;
    logic [31:0]  s_wdata;
    logic         s_wvalid;
    logic         s_wready;
    logic [63:0]  s_raddr;
    logic [31:0]  s_rdata;
    logic         s_rvalid;
    logic         s_rready;
    logic         arb_timeout;
    logic [7:0]   arb_timeout_cnt;

    acc_access_arbiter #(
        .addr_width     (64),
        .data_width     (32),
        .timeout_cycles (16'd4)
    ) dut (
        .sys__clk         (clk),
        .sys__arstn       (rst_n),
        .m__waddr         (m_waddr),
        .m__wdata         (m_wdata),
        .m__wvalid        (m_wvalid),
        .m__wready        (m_wready),
        .m__raddr         (m_raddr),
        .m__rdata         (m_rdata),
        .m__rvalid        (m_rvalid),
        .m__rready        (m_rready),
        .s__waddr         (s_waddr),
        .s__wdata         (s_wdata),
        .s__wvalid        (s_wvalid),
        .s__wready        (s_wready),
        .s__raddr         (s_raddr),
        .s__rdata         (s_rdata),
        .s__rvalid        (s_rvalid),
        .s__rready        (s_rready),
        .arb__timeout     (arb_timeout),
        .arb__timeout_cnt (arb_timeout_cnt)
    );

    typedef struct {
        bit          m;
        bit          rd;
        logic [63:0] addr;
        logic [31:0] data;
        int          dly;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          to;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cnt_exp = 0;
    exp_t sb[$];
    int   ord[$];
    vec_t tbl[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one transaction; expected completion pushed before stimulus runs
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        bit   done;
        int   mi;
        int   slot;
        mi = v.m ? 1 : 0;
        e.to = (v.dly > 3);
        e.rdata = e.to ? 32'hDEADBEEF : v.data;
        sb.push_back(e);
        slot = v.rd ? 2 * mi + 1 : 2 * mi;
        if (v.rd) begin
            m_raddr[mi*64 +: 64] = v.addr;
            m_rvalid[mi] = 1'b1;
            s_rdata = v.data;
        end else begin
            m_waddr[mi*64 +: 64] = v.addr;
            m_wdata[mi*32 +: 32] = v.data;
            m_wvalid[mi] = 1'b1;
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 12 && !done; cyc++) begin
            step();
            s_wready = 1'b0;
            s_rready = 1'b0;
            #1;
            chk("tgt_valid", {62'd0, s_wvalid, s_rvalid},
                v.rd ? 64'd1 : 64'd2);
            if (v.rd) begin
                chk("raddr", s_raddr, v.addr);
            end else begin
                chk("waddr", s_waddr, v.addr);
                chk("wdata", {32'd0, s_wdata}, {32'd0, v.data});
            end
            if (cyc == v.dly) begin
                if (v.rd) s_rready = 1'b1;
                else s_wready = 1'b1;
            end
            #1;
            if ((m_wready | m_rready) != 2'b00) begin
                got = sb.pop_front();
                chk("req_ready", {60'd0, m_rready, m_wready},
                    64'd1 << (v.rd ? 2 + mi : mi));
                chk("rdata", m_rdata,
                    v.rd ? ({32'd0, got.rdata} << (32 * mi)) : 64'd0);
                chk("done_cycle", cyc, got.to ? 3 : v.dly);
                done = 1'b1;
            end
        end
        if (!done) begin
            got = sb.pop_front();
            chk("ready_bound", 64'd0, 64'd1);
        end
        step();
        s_wready = 1'b0;
        s_rready = 1'b0;
        m_wvalid = 2'b00;
        m_rvalid = 2'b00;
        if (e.to && cnt_exp != 255) cnt_exp++;
        chk("tmo_pulse", {63'd0, arb_timeout}, {63'd0, e.to});
        chk("tmo_cnt", {56'd0, arb_timeout_cnt}, 64'(cnt_exp));
        chk("back_idle", {62'd0, s_wvalid, s_rvalid}, 64'd0);
        step();
        chk("tmo_one_cycle", {63'd0, arb_timeout}, 64'd0);
        if (slot < 0) chk("slot", 64'(slot), 64'd0);
    endtask

    initial begin
        int   ngr;
        int   last;
        int   slot;
        int   expd;
        vec_t tv;

        tbl[0] = '{m: 1'b0, rd: 1'b0, addr: 64'h10,
                   data: 32'hA5A5A5A5, dly: 2};
        tbl[1] = '{m: 1'b1, rd: 1'b1, addr: 64'h20,
                   data: 32'h12345678, dly: 0};
        tbl[2] = '{m: 1'b1, rd: 1'b0, addr: 64'hFFFF_FFFF_FFFF_FFF0,
                   data: 32'h0BADF00D, dly: 1};
        tbl[3] = '{m: 1'b0, rd: 1'b1, addr: 64'h40,
                   data: 32'hCAFEBABE, dly: 3};
        tbl[4] = '{m: 1'b0, rd: 1'b1, addr: 64'h44,
                   data: 32'h11111111, dly: 99};
        tbl[5] = '{m: 1'b1, rd: 1'b0, addr: 64'h50,
                   data: 32'h5A5A5A5A, dly: 99};
        tbl[6] = '{m: 1'b1, rd: 1'b1, addr: 64'h60,
                   data: 32'h87654321, dly: 3};

        rst_n = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_wvalid = '0;
        m_raddr = '0;
        m_rvalid = '0;
        s_wready = 1'b0;
        s_rready = 1'b0;
        s_rdata = '0;

        step();
        step();
        chk("rst_valids", {58'd0, s_wvalid, s_rvalid, m_wready, m_rready},
            64'd0);
        chk("rst_waddr", s_waddr, 64'd0);
        chk("rst_rdata", m_rdata, 64'd0);
        chk("rst_tmo", {55'd0, arb_timeout, arb_timeout_cnt}, 64'd0);
        rst_n = 1'b1;
        step();

        s_wready = 1'b1;
        s_rready = 1'b1;
        #1;
        chk("idle_ready_ignored", {62'd0, m_wready, m_rready}, 64'd0);
        step();
        chk("idle_no_valid", {62'd0, s_wvalid, s_rvalid}, 64'd0);
        s_wready = 1'b0;
        s_rready = 1'b0;

        // all four slots contending, target always ready
        m_waddr = {64'h300, 64'h100};
        m_raddr = {64'h400, 64'h200};
        m_wvalid = 2'b11;
        m_rvalid = 2'b11;
        ord = '{0, 1, 2, 3, 0};
        ngr = 0;
        last = -1;
        for (int cyc = 0; cyc < 20 && ngr < 5; cyc++) begin
            step();
            s_wready = 1'b0;
            s_rready = 1'b0;
            #1;
            if (s_wvalid || s_rvalid) begin
                if (s_wvalid) slot = (s_waddr == 64'h300) ? 2 : 0;
                else slot = (s_raddr == 64'h400) ? 3 : 1;
                expd = ord.pop_front();
                chk("grant_order", 64'(slot), 64'(expd));
                if (last < 0) chk("first_latency", 64'(cyc), 64'd0);
                else chk("grant_gap", 64'(cyc - last), 64'd2);
                last = cyc;
                s_wready = s_wvalid;
                s_rready = s_rvalid;
                #1;
                chk("order_ready", {60'd0, m_rready, m_wready},
                    (expd == 0) ? 64'd1 : (expd == 1) ? 64'd4 :
                    (expd == 2) ? 64'd2 : 64'd8);
                ngr++;
            end
        end
        if (ngr < 5) chk("order_bound", 64'(ngr), 64'd5);
        step();
        s_wready = 1'b0;
        s_rready = 1'b0;
        m_wvalid = 2'b00;
        m_rvalid = 2'b00;
        step();
        chk("order_idle", {62'd0, s_wvalid, s_rvalid}, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        tv = '{m: 1'b0, rd: 1'b1, addr: 64'h80,
               data: 32'h0, dly: 99};
        for (int k = 0; k < 300; k++) run_vec(tv);
        chk("cnt_saturated", {56'd0, arb_timeout_cnt}, 64'd255);

        // leave pointer at 3, then abort a slot-3 read by reset
        tv = '{m: 1'b1, rd: 1'b0, addr: 64'h90,
               data: 32'h99, dly: 0};
        run_vec(tv);
        m_raddr[127:64] = 64'h77;
        m_rvalid[1] = 1'b1;
        step();
        chk("pre_rst_xfer", {63'd0, s_rvalid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valids", {58'd0, s_wvalid, s_rvalid, m_wready, m_rready},
            64'd0);
        chk("arst_raddr", s_raddr, 64'd0);
        chk("arst_waddr", s_waddr, 64'd0);
        chk("arst_rdata", m_rdata, 64'd0);
        chk("arst_tmo", {55'd0, arb_timeout, arb_timeout_cnt}, 64'd0);
        cnt_exp = 0;
        m_raddr[63:0] = 64'h88;
        m_rvalid[0] = 1'b1;
        step();
        chk("in_rst_ready", {62'd0, m_wready, m_rready}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_grant", s_raddr, 64'h88);
        s_rdata = 32'h0F0F0F0F;
        s_rready = 1'b1;
        #1;
        chk("post_rst_ready", {62'd0, m_rready}, 64'd1);
        chk("post_rst_rdata", m_rdata, 64'h0F0F0F0F);
        step();
        s_rready = 1'b0;
        m_rvalid[0] = 1'b0;
        step();
        chk("post_rst_next", s_raddr, 64'h77);
        s_rready = 1'b1;
        #1;
        chk("post_rst_ready2", {62'd0, m_rready}, 64'd2);
        chk("post_rst_rdata2", m_rdata, 64'h0F0F0F0F_00000000);
        step();
        s_rready = 1'b0;
        m_rvalid = 2'b00;
        step();
        chk("final_idle", {62'd0, s_wvalid, s_rvalid}, 64'd0);
        chk("final_cnt", {56'd0, arb_timeout_cnt}, 64'(cnt_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
